// File: rtl/perceptron_pkg.sv
// Shared types and constants for the perceptron frame loader.
package perceptron_pkg;

  localparam int PFL_N_INPUTS = 4;
  localparam int PFL_W        = 8;

  localparam logic [7:0] HEADER_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    LOAD_X,
    LOAD_B,
    CHECK,
    FIRE,
    WAIT_DONE
  } pfl_state_e;

  function automatic logic is_loading(input pfl_state_e s);
    return (s == LOAD_W) || (s == LOAD_X) || (s == LOAD_B);
  endfunction

endpackage

// File: rtl/perceptron_byte_checksum.sv
// Modulo-256 byte accumulator with synchronous clear and enable.
module perceptron_byte_checksum (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic [7:0] byte_i,
  output logic [7:0] sum_o
);

  logic [7:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clr_i)
      sum_d = '0;
    else if (en_i)
      sum_d = sum_q + byte_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sum_q <= '0;
    else
      sum_q <= sum_d;
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/perceptron_frame_loader.sv
// Framed byte-stream loader feeding the perceptron core.
// Trailing checksum byte enabled by PERCEPTRON_LOADER_CHECKSUM_EN.
module perceptron_frame_loader
  import perceptron_pkg::*;
#(
  parameter int N_INPUTS = PFL_N_INPUTS,
  parameter int W        = PFL_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  input  logic                  frame_start,
  output logic [N_INPUTS*W-1:0] weights_flat,
  output logic [N_INPUTS*W-1:0] inputs_flat,
  output logic [W-1:0]          bias,
  output logic                  start,
  input  logic                  core_done,
  output logic                  busy,
  output logic                  err
);

  localparam int IW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam logic [IW-1:0] LAST = IW'(N_INPUTS - 1);

  pfl_state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;

  logic [N_INPUTS*W-1:0] w_stg_q, x_stg_q;
  logic [W-1:0]          b_stg_q;
  logic [N_INPUTS*W-1:0] w_out_q, x_out_q;
  logic [W-1:0]          b_out_q;

  logic ready_q, busy_q, start_q;
  logic ready_d, busy_d, start_d;

  logic          acc;
  logic          commit;
  logic [W-1:0]  bval;
  logic [W-1:0]  b_commit;

  assign acc  = byte_valid & ready_q;
  assign bval = W'($signed(byte_in));

`ifdef PERCEPTRON_LOADER_CHECKSUM_EN
  logic [7:0] sum;
  logic [7:0] total;
  logic       fail;
  logic       err_q;

  perceptron_byte_checksum u_csum (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (frame_start | (state_q == IDLE)),
    .en_i   (acc & ~frame_start & is_loading(state_q)),
    .byte_i (byte_in),
    .sum_o  (sum)
  );

  assign total = sum + byte_in;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
`ifdef PERCEPTRON_LOADER_CHECKSUM_EN
    fail    = 1'b0;
`endif
    if (frame_start) begin
      state_d = IDLE;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (acc && byte_in == HEADER_BYTE) begin
            state_d = LOAD_W;
            idx_d   = '0;
          end
        end
        LOAD_W: begin
          if (acc) begin
            if (idx_q == LAST) begin
              state_d = LOAD_X;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        LOAD_X: begin
          if (acc) begin
            if (idx_q == LAST) begin
              state_d = LOAD_B;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        LOAD_B: begin
          if (acc) begin
`ifdef PERCEPTRON_LOADER_CHECKSUM_EN
            state_d = CHECK;
`else
            state_d = FIRE;
`endif
          end
        end
`ifdef PERCEPTRON_LOADER_CHECKSUM_EN
        CHECK: begin
          if (acc) begin
            if (total == 8'h00) begin
              state_d = FIRE;
            end else begin
              state_d = IDLE;
              fail    = 1'b1;
            end
          end
        end
`endif
        FIRE:      state_d = WAIT_DONE;
        WAIT_DONE: if (core_done) state_d = IDLE;
        default:   state_d = IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they align with it.
  always_comb begin
    ready_d = (state_d != FIRE) && (state_d != WAIT_DONE);
    busy_d  = (state_d != IDLE);
    start_d = (state_d == FIRE);
  end

  assign commit   = (state_d == FIRE) && (state_q != FIRE);
  assign b_commit = (state_q == LOAD_B) ? bval : b_stg_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      start_q <= start_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_stg_q <= '0;
      x_stg_q <= '0;
      b_stg_q <= '0;
    end else if (acc && !frame_start) begin
      unique case (state_q)
        LOAD_W:  w_stg_q[int'(idx_q)*W +: W] <= bval;
        LOAD_X:  x_stg_q[int'(idx_q)*W +: W] <= bval;
        LOAD_B:  b_stg_q <= bval;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_out_q <= '0;
      x_out_q <= '0;
      b_out_q <= '0;
    end else if (commit) begin
      w_out_q <= w_stg_q;
      x_out_q <= x_stg_q;
      b_out_q <= b_commit;
    end
  end

`ifdef PERCEPTRON_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_q <= 1'b0;
    else if (frame_start)
      err_q <= 1'b0;
    else if (fail)
      err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign byte_ready   = ready_q;
  assign busy         = busy_q;
  assign start        = start_q;
  assign weights_flat = w_out_q;
  assign inputs_flat  = x_out_q;
  assign bias         = b_out_q;

endmodule

// File: tb/tb_perceptron_frame_loader.sv
// Scoreboard bench for perceptron_frame_loader (N_INPUTS=4, W=8).
module tb_perceptron_frame_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        frame_start;
  logic [31:0] weights_flat;
  logic [31:0] inputs_flat;
  logic [7:0]  bias;
  logic        start;
  logic        core_done;
  logic        busy;
  logic        err;

  perceptron_frame_loader #(.N_INPUTS(4), .W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .byte_in      (byte_in),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .frame_start  (frame_start),
    .weights_flat (weights_flat),
    .inputs_flat  (inputs_flat),
    .bias         (bias),
    .start        (start),
    .core_done    (core_done),
    .busy         (busy),
    .err          (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] w;
    logic [31:0] x;
    logic [7:0]  b;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_start = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (!rst && start) begin
      exp_t e;
      n_start++;
      if (sb.size() == 0) begin
        chk("spurious_start", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("weights", weights_flat, e.w);
        chk("inputs", inputs_flat, e.x);
        chk("bias", bias, e.b);
      end
    end
  end

  task automatic send(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    byte_valid = 1'b1;
    byte_in    = b;
    while (!byte_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("send_timeout", 1, 0);
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] w, input logic [31:0] x,
                            input logic [7:0] b, input bit bad,
                            input bit hdr);
    logic [7:0] s = 8'h00;
    if (hdr) send(8'hA5);
    for (int k = 0; k < 4; k++) begin
      send(w[k*8 +: 8]);
      s = s + w[k*8 +: 8];
    end
    for (int k = 0; k < 4; k++) begin
      send(x[k*8 +: 8]);
      s = s + x[k*8 +: 8];
    end
    send(b);
    s = s + b;
`ifdef PERCEPTRON_LOADER_CHECKSUM_EN
    send(bad ? 8'h00 : 8'h00 - s);
`endif
  endtask

  task automatic expect_fire(input string tag);
    chk({tag, "_start"}, start, 1);
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_ready"}, byte_ready, 0);
    @(posedge clk);
    #1;
    chk({tag, "_start_1cyc"}, start, 0);
  endtask

  task automatic finish_core(input string tag);
    repeat (3) @(negedge clk);
    chk({tag, "_busy_hold"}, busy, 1);
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    chk({tag, "_ready_back"}, byte_ready, 1);
    chk({tag, "_idle"}, busy, 0);
  endtask

  localparam logic [31:0] GW = 32'h04030201;
  localparam logic [31:0] GX = 32'h08070605;
  localparam logic [7:0]  GB = 8'hFF;
  localparam logic [31:0] HW = 32'h40302010;
  localparam logic [31:0] HX = 32'h017FF080;
  localparam logic [7:0]  HB = 8'h9C;

  initial begin
    int n;
    rst = 1'b1;
    byte_in = 8'h00;
    byte_valid = 1'b0;
    frame_start = 1'b0;
    core_done = 1'b0;
    #1;
    chk("rst_weights", weights_flat, 0);
    chk("rst_inputs", inputs_flat, 0);
    chk("rst_bias", bias, 0);
    chk("rst_start", start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_ready", byte_ready, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Good frame
    sb.push_back('{w: GW, x: GX, b: GB});
    send_frame(GW, GX, GB, 1'b0, 1'b1);
    expect_fire("good");
    finish_core("good");

    // Bad checksum: nothing committed, err raised
    send_frame(HW, HX, HB, 1'b1, 1'b1);
`ifdef PERCEPTRON_LOADER_CHECKSUM_EN
    chk("bad_err", err, 1);
    chk("bad_busy", busy, 0);
    chk("bad_start", start, 0);
    chk("bad_keep_w", weights_flat, GW);
    chk("bad_keep_b", bias, GB);
`else
    chk("nock_err", err, 0);
    sb.push_back('{w: HW, x: HX, b: HB});
    expect_fire("nock");
    finish_core("nock");
`endif

    // Leading junk dropped
    send(8'h00);
    send(8'h11);
    chk("junk_idle", busy, 0);
    sb.push_back('{w: GW, x: GX, b: GB});
    send_frame(GW, GX, GB, 1'b0, 1'b1);
    expect_fire("junk");

    // Backpressure in WAIT_DONE, header held until core_done
    @(negedge clk);
    byte_valid = 1'b1;
    byte_in    = 8'hA5;
    repeat (4) begin
      @(negedge clk);
      chk("bp_ready", byte_ready, 0);
    end
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    chk("bp_ready_back", byte_ready, 1);
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    chk("bp_hdr_taken", busy, 1);
    sb.push_back('{w: HW, x: HX, b: HB});
    send_frame(HW, HX, HB, 1'b0, 1'b0);
    expect_fire("bp");
    finish_core("bp");

    // Abort after two weights; header offered with frame_start is dropped
    send(8'hA5);
    send(8'h77);
    send(8'h66);
    @(negedge clk);
    frame_start = 1'b1;
    byte_valid  = 1'b1;
    byte_in     = 8'hA5;
    @(negedge clk);
    frame_start = 1'b0;
    byte_valid  = 1'b0;
    chk("abort_err", err, 0);
    chk("abort_idle", busy, 0);
    chk("abort_keep_w", weights_flat, HW);
    sb.push_back('{w: GW, x: GX, b: GB});
    send_frame(GW, GX, GB, 1'b0, 1'b1);
    expect_fire("abort");
    finish_core("abort");

    // Asynchronous reset in LOAD_X
    send(8'hA5);
    for (int k = 0; k < 6; k++) send(8'h30 + 8'(k));
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_weights", weights_flat, 0);
    chk("arst_inputs", inputs_flat, 0);
    chk("arst_bias", bias, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ready", byte_ready, 1);
    chk("arst_err", err, 0);
    @(negedge clk);
    rst = 1'b0;
    sb.push_back('{w: GW, x: GX, b: GB});
    send_frame(GW, GX, GB, 1'b0, 1'b1);
    expect_fire("arst");
    finish_core("arst");

    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("sb_empty", sb.size(), 0);
`ifdef PERCEPTRON_LOADER_CHECKSUM_EN
    chk("start_count", n_start, 5);
`else
    chk("start_count", n_start, 6);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
